// File: rtl/measurement_packetizer.sv
// -----------------------------------------------------------------------------
// measurement_packetizer
//
// Frames each averaged ring-oscillator count into a 5-byte packet and hands the
// packet to the UART transmitter one byte at a time over its start/busy
// handshake:
//
//   HEADER, SEQ, sample[15:8], sample[7:0], CHK   (CHK = SEQ ^ MSB ^ LSB)
//
// SEQ is an 8-bit counter that advances after every completed packet. A
// one-deep hold buffer absorbs one sample that arrives while a packet is in
// flight. Any further sample is dropped and flagged on the sticky overrun bit.
//
// Ports
//   clk            system clock (shared with the averaging stage and UART)
//   reset          asynchronous, active-high reset
//   sample_valid   one-cycle pulse: sample carries a new average
//   sample         averaged count, used only when sample_valid=1
//   tx_busy        UART transmitter busy
//   tx_start       one-cycle request to the UART to send tx_data
//   tx_data        byte to transmit, stable from tx_start until tx_busy falls
//   busy           packet in progress or one queued
//   overrun        sticky: at least one sample was dropped
//   clear_overrun  synchronous clear of overrun (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module measurement_packetizer #(
  parameter int          WIDTH  = 16,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             overrun,
  input  logic             clear_overrun
);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'd4;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seq_q, seq_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             overrun_q, overrun_d;

  // Byte of the packet at position idx. SEQ is stable for the whole packet
  // because it only advances on the transition back to IDLE.
  function automatic logic [7:0] packet_byte(input logic [2:0]       idx,
                                             input logic [7:0]       seq,
                                             input logic [WIDTH-1:0] frame);
    logic [7:0] msb;
    logic [7:0] lsb;
    msb = frame[WIDTH-1:WIDTH-8];
    lsb = frame[7:0];
    case (idx)
      3'd0:    packet_byte = HEADER;
      3'd1:    packet_byte = seq;
      3'd2:    packet_byte = msb;
      3'd3:    packet_byte = lsb;
      default: packet_byte = seq ^ msb ^ lsb;
    endcase
  endfunction

  // Next-state and output logic.
  always_comb begin
    logic idle_direct;  // sample goes straight into the frame this cycle
    logic hold_free;    // hold register can accept a sample this cycle
    logic drop;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    frame_d      = frame_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    drop         = 1'b0;

    idle_direct = (state_q == IDLE) && !hold_valid_q && sample_valid;
    // In IDLE a held sample is consumed this cycle, so the slot frees and
    // can refill in the same cycle.
    hold_free   = !hold_valid_q || (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          frame_d      = hold_q;
          hold_valid_d = 1'b0;
          idx_d        = 3'd0;
          state_d      = START;
        end else if (sample_valid) begin
          frame_d = sample;
          idx_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = packet_byte(idx_q, seq_q, frame_q);
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q < LAST_IDX) begin
            // The UART is already known idle, so the START step is folded
            // into this cycle and the next byte follows the busy fall by
            // exactly one cycle.
            idx_d      = idx_q + 3'd1;
            tx_start_d = 1'b1;
            tx_data_d  = packet_byte(idx_q + 3'd1, seq_q, frame_q);
            state_d    = WAIT_ACK;
          end else begin
            seq_d   = seq_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold buffer: oldest sample wins, newer ones are dropped.
    if (sample_valid && !idle_direct) begin
      if (hold_free) begin
        hold_d       = sample;
        hold_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    // Set has priority over clear.
    overrun_d = (overrun_q & ~clear_overrun) | drop;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      seq_q        <= 8'h00;
      frame_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      frame_q      <= frame_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != IDLE) || hold_valid_q;

endmodule

// File: tb/tb_measurement_packetizer.sv
// -----------------------------------------------------------------------------
// tb_measurement_packetizer
//
// Self-checking bench for measurement_packetizer. A simple UART model raises
// tx_busy one cycle after each tx_start and holds it for busy_len cycles.
// Expected packet bytes are pushed to a scoreboard queue when a sample is
// driven and popped by a monitor on every tx_start.
// -----------------------------------------------------------------------------
module tb_measurement_packetizer;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        overrun;
  logic        clear_overrun;

  logic        force_busy = 1'b0;
  logic        uart_busy  = 1'b0;
  int          busy_cnt   = 0;
  int          busy_len   = 10;

  int checks = 0;
  int errors = 0;

  measurement_packetizer #(.WIDTH(16), .HEADER(HDR)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample        (sample),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .busy          (busy),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  assign tx_busy = uart_busy | force_busy;

  // UART model: busy from the cycle after tx_start, for busy_len cycles.
  always @(posedge clk) begin
    if (tx_start) begin
      uart_busy <= 1'b1;
      busy_cnt  <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt  <= 0;
      uart_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and monitor.
  logic [7:0] sb[$];
  logic [7:0] exp_seq   = 8'h00;
  int         n_starts  = 0;
  int         cyc       = 0;
  int         fall_cyc  = 0;
  int         pkt_pos   = 0;
  logic       prev_busy = 1'b0;
  logic       prev_start = 1'b0;
  logic       have_last = 1'b0;
  logic [7:0] last_byte = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pkt_pos    = 0;
      prev_start = 1'b0;
      have_last  = 1'b0;
      prev_busy  = tx_busy;
    end else begin
      if (prev_busy && !tx_busy) fall_cyc = cyc;
      if (tx_start) begin
        n_starts++;
        check("pulse_len", {31'd0, prev_start}, 32'd0);
        if (pkt_pos != 0) check("byte_gap", cyc - fall_cyc, 32'd1);
        if (sb.size() == 0) check("unexpected_byte", sb.size(), 32'd1);
        else check("byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
        pkt_pos   = (pkt_pos == 4) ? 0 : pkt_pos + 1;
        have_last = 1'b1;
        last_byte = tx_data;
      end else if (have_last && tx_busy) begin
        check("tx_data_hold", {24'd0, tx_data}, {24'd0, last_byte});
      end
      prev_start = tx_start;
      prev_busy  = tx_busy;
    end
  end

  task automatic expect_packet(input logic [15:0] s);
    sb.push_back(HDR);
    sb.push_back(exp_seq);
    sb.push_back(s[15:8]);
    sb.push_back(s[7:0]);
    sb.push_back(exp_seq ^ s[15:8] ^ s[7:0]);
    exp_seq = exp_seq + 8'd1;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic send(input logic [15:0] s);
    sample       = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    sample_valid  = 1'b0;
    clear_overrun = 1'b0;
    force_busy    = 1'b0;
    #1;
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_data},  32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_overrun",  {31'd0, overrun},  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_seq = 8'h00;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (!busy && !tx_busy && sb.size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    check("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_starts(input int target, input logic want_busy);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (n_starts >= target && tx_busy == want_busy) done = 1'b1;
      else @(negedge clk);
    end
    check("start_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int base;
    int early;
    reset         = 1'b1;
    sample_valid  = 1'b0;
    sample        = 16'h0000;
    clear_overrun = 1'b0;
    @(negedge clk);

    // 1: single packet, latency, start count, SEQ advance.
    do_reset();
    base = n_starts;
    expect_packet(16'h1234);
    send(16'h1234);
    check("latency_n1", {31'd0, tx_start}, 32'd0);
    check("busy_active", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("latency_n2", {31'd0, tx_start}, 32'd1);
    check("latency_hdr", {24'd0, tx_data}, {24'd0, HDR});
    wait_idle();
    check("start_count", n_starts - base, 32'd5);
    expect_packet(16'h0000);
    send(16'h0000);
    wait_idle();

    // 2: back-to-back packets (second one via the hold buffer).
    do_reset();
    expect_packet(16'hABCD);
    send(16'hABCD);
    expect_packet(16'h0001);
    send(16'h0001);
    wait_idle();
    check("b2b_overrun", {31'd0, overrun}, 32'd0);

    // 3: three samples during one packet; oldest kept, others dropped.
    do_reset();
    expect_packet(16'h5555);
    send(16'h5555);
    repeat (20) @(negedge clk);
    expect_packet(16'h1111);
    send(16'h1111);
    send(16'h2222);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    sample        = 16'h3333;
    sample_valid  = 1'b1;
    clear_overrun = 1'b1;
    @(negedge clk);
    sample_valid  = 1'b0;
    clear_overrun = 1'b0;
    check("overrun_set_wins", {31'd0, overrun}, 32'd1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("overrun_clear", {31'd0, overrun}, 32'd0);
    wait_idle();

    // 7: new sample in the same cycle IDLE consumes the hold buffer.
    do_reset();
    base = n_starts;
    expect_packet(16'h7777);
    send(16'h7777);
    expect_packet(16'h8888);
    send(16'h8888);
    wait_starts(base + 5, 1'b1);
    wait_starts(base + 5, 1'b0);
    @(negedge clk);
    expect_packet(16'h9999);
    send(16'h9999);
    wait_idle();
    check("refill_overrun", {31'd0, overrun}, 32'd0);

    // 4: UART busy when the sample arrives.
    do_reset();
    force_busy = 1'b1;
    expect_packet(16'h4242);
    send(16'h4242);
    early = 0;
    repeat (6) begin
      if (tx_start) early++;
      @(negedge clk);
    end
    check("start_while_busy", early, 32'd0);
    force_busy = 1'b0;
    wait_idle();

    // 5: SEQ wrap FF -> 00 (257 packets, short UART busy).
    do_reset();
    busy_len = 2;
    for (int i = 0; i < 257; i++) begin
      logic [7:0] k;
      k = i[7:0];
      expect_packet({k, ~k});
      send({k, ~k});
      wait_idle();
    end
    busy_len = 10;

    // 6: reset during the MSB byte with a sample queued and one dropped.
    do_reset();
    base = n_starts;
    expect_packet(16'hBEEF);
    send(16'hBEEF);
    send(16'h0102);
    send(16'h0304);
    wait_starts(base + 3, 1'b1);
    @(negedge clk);
    check("overrun_pre_reset", {31'd0, overrun}, 32'd1);
    do_reset();
    expect_packet(16'h0BAD);
    send(16'h0BAD);
    wait_idle();

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
